video_mem_server: RTL and testbench

VIDEO_MEM_SERVER -- requirements
Module: video_mem_server

---
 rtl/vmem_pkg.sv | 32 +++
 rtl/vmem_bank.sv | 30 +++
 rtl/video_mem_server.sv | 151 +++++++++++++++
 tb/tb_video_mem_server.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and default sizes for the video memory server.
package vmem_pkg;

  localparam int unsigned ADDR_W_DEF     = 10;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned STARVE_MAX_DEF = 8;

  typedef enum logic {
    TILE    = 1'b0,
    PALETTE = 1'b1
  } bank_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2,
    BOTH = 2'd3
  } owner_state_t;

  // Owner for the next cycle, derived from this cycle's grants.
  function automatic owner_state_t next_owner(input logic vid_g, input logic cpu_g);
    owner_state_t s;
    case ({vid_g, cpu_g})
      2'b10:   s = VID;
      2'b01:   s = CPU;
      2'b11:   s = BOTH;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vmem_bank.sv
// Single-port synchronous RAM, write-first, no reset on contents.
module vmem_bank #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per cycle; a write also presents the new word on rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/video_mem_server.sv
// Two-bank (tile/palette) memory shared by the tile renderer and the CPU.
module video_mem_server
  import vmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic              vid_req,
  input  logic              vid_sel,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic              rst_q;
  logic              active;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_hit;
  bank_sel_t         vid_bank;
  bank_sel_t         cpu_bank;
  logic              conflict;
  logic              cpu_wins;

  owner_state_t      state;
  bank_sel_t         vid_sel_q;
  bank_sel_t         cpu_sel_q;
  logic              cpu_rd_q;
  logic [DATA_W-1:0] vid_hold;
  logic [DATA_W-1:0] cpu_hold;

  logic              tile_vid, tile_cpu, pal_vid, pal_cpu;
  logic              tile_en, tile_we, pal_en, pal_we;
  logic [ADDR_W-1:0] tile_addr, pal_addr;
  logic [DATA_W-1:0] tile_q, pal_q;
  logic [DATA_W-1:0] vid_rd, cpu_rd;

  // Grants stay off during reset and for the first cycle after it.
  assign active     = !rst && !rst_q;
  assign vid_bank   = bank_sel_t'(vid_sel);
  assign cpu_bank   = bank_sel_t'(cpu_addr[ADDR_W]);
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

  // Same-cycle arbitration; only a bank conflict needs a winner.
  always_comb begin
    conflict = vid_req && cpu_req && (vid_bank == cpu_bank);
    cpu_wins = blank || starve_hit;
    vid_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    if (active) begin
      vid_gnt = vid_req && !(conflict && cpu_wins);
      cpu_gnt = cpu_req && !(conflict && !cpu_wins);
    end
  end

  // Route each granted requester to its bank.
  always_comb begin
    tile_vid  = vid_gnt && (vid_bank == TILE);
    tile_cpu  = cpu_gnt && (cpu_bank == TILE);
    pal_vid   = vid_gnt && (vid_bank == PALETTE);
    pal_cpu   = cpu_gnt && (cpu_bank == PALETTE);
    tile_en   = tile_vid || tile_cpu;
    tile_we   = tile_cpu && cpu_we;
    tile_addr = tile_cpu ? cpu_addr[ADDR_W-1:0] : vid_addr;
    pal_en    = pal_vid || pal_cpu;
    pal_we    = pal_cpu && cpu_we;
    pal_addr  = pal_cpu ? cpu_addr[ADDR_W-1:0] : vid_addr;
  end

  vmem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_tile (
    .clk   (clk),
    .en    (tile_en),
    .we    (tile_we),
    .addr  (tile_addr),
    .wdata (cpu_wdata),
    .rdata (tile_q)
  );

  vmem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pal (
    .clk   (clk),
    .en    (pal_en),
    .we    (pal_we),
    .addr  (pal_addr),
    .wdata (cpu_wdata),
    .rdata (pal_q)
  );

  // Delayed reset flag used to hold grants off one cycle past reset.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // CPU starvation counter: counts denied cycles, saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Owner state machine: records last cycle's grants and read routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vid_sel_q <= TILE;
      cpu_sel_q <= TILE;
      cpu_rd_q  <= 1'b0;
    end else begin
      state    <= next_owner(vid_gnt, cpu_gnt);
      cpu_rd_q <= cpu_gnt && !cpu_we;
      if (vid_gnt) vid_sel_q <= vid_bank;
      if (cpu_gnt) cpu_sel_q <= cpu_bank;
    end
  end

  assign vid_rd     = (vid_sel_q == PALETTE) ? pal_q : tile_q;
  assign cpu_rd     = (cpu_sel_q == PALETTE) ? pal_q : tile_q;
  assign vid_valid  = !rst && ((state == VID) || (state == BOTH));
  assign cpu_rvalid = !rst && ((state == CPU) || (state == BOTH)) && cpu_rd_q;

  // Hold registers keep the last delivered word while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_hold <= '0;
      cpu_hold <= '0;
    end else begin
      if (vid_valid)  vid_hold <= vid_rd;
      if (cpu_rvalid) cpu_hold <= cpu_rd;
    end
  end

  assign vid_data  = rst ? '0 : (vid_valid  ? vid_rd : vid_hold);
  assign cpu_rdata = rst ? '0 : (cpu_rvalid ? cpu_rd : cpu_hold);

endmodule

// File: tb/tb_video_mem_server.sv
// Directed self-checking bench for video_mem_server.
module tb_video_mem_server;

  logic        clk;
  logic        rst;
  logic        blank;
  logic        vid_req;
  logic        vid_sel;
  logic [9:0]  vid_addr;
  logic        vid_gnt;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  video_mem_server #(.ADDR_W(10), .DATA_W(8), .STARVE_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .blank      (blank),
    .vid_req    (vid_req),
    .vid_sel    (vid_sel),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_vgnt"},   32'(vid_gnt),    32'd0);
    check({tag, "_vvalid"}, 32'(vid_valid),  32'd0);
    check({tag, "_vdata"},  32'(vid_data),   32'd0);
    check({tag, "_cgnt"},   32'(cpu_gnt),    32'd0);
    check({tag, "_cvalid"}, 32'(cpu_rvalid), 32'd0);
    check({tag, "_cdata"},  32'(cpu_rdata),  32'd0);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    blank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    check("wr_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [10:0] a, input logic [7:0] exp);
    blank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
    check({tag, "_rdata"},  32'(cpu_rdata),  32'(exp));
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; blank = 1'b0; vid_req = 1'b0; vid_sel = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Power-on reset, then the blocked cycle after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("init_rst");
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    check_quiet("init_exit");
    next_cycle();

    // Preload known words.
    cpu_write(11'h005, 8'h11);
    cpu_write(11'h010, 8'h3C);
    cpu_write(11'h020, 8'h7E);
    cpu_write(11'h001, 8'h5A);
    cpu_write(11'h401, 8'hC3);
    cpu_write(11'h040, 8'h99);

    // Palette write 0x3FF then immediate read-back.
    cpu_write(11'h7FF, 8'hA5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    @(negedge clk);
    check("wr_rd_gnt",     32'(cpu_gnt),    32'd1);
    check("wr_no_rvalid",  32'(cpu_rvalid), 32'd0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check("wr_rd_rvalid",  32'(cpu_rvalid), 32'd1);
    check("wr_rd_data",    32'(cpu_rdata),  32'hA5);
    next_cycle();
    @(negedge clk);
    check("hold_rvalid",   32'(cpu_rvalid), 32'd0);
    check("hold_rdata",    32'(cpu_rdata),  32'hA5);
    next_cycle();

    // Reset mid-access with requests pending; no write may land.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
    @(negedge clk);
    check("pre_rst_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'hEE;
    vid_req = 1'b1; vid_sel = 1'b0; vid_addr = 10'h005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("rst");
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_exit");
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;
    next_cycle();
    cpu_read("no_rst_write", 11'h005, 8'h11);

    // Active-video conflict: video wins until it drops its request.
    blank = 1'b0;
    vid_req = 1'b1; vid_sel = 1'b0; vid_addr = 10'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
    @(negedge clk);
    check("cf1_vgnt", 32'(vid_gnt), 32'd1);
    check("cf1_cgnt", 32'(cpu_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    check("cf2_cgnt",   32'(cpu_gnt),   32'd0);
    check("cf2_vvalid", 32'(vid_valid), 32'd1);
    check("cf2_vdata",  32'(vid_data),  32'h3C);
    next_cycle();
    vid_req = 1'b0;
    @(negedge clk);
    check("cf3_cgnt", 32'(cpu_gnt), 32'd1);
    check("cf3_vgnt", 32'(vid_gnt), 32'd0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cf4_rvalid", 32'(cpu_rvalid), 32'd1);
    check("cf4_rdata",  32'(cpu_rdata),  32'h7E);
    check("cf4_vvalid", 32'(vid_valid),  32'd0);
    check("cf4_vhold",  32'(vid_data),   32'h3C);
    next_cycle();

    // A denied write that is withdrawn leaves memory untouched.
    vid_req = 1'b1; vid_sel = 1'b0; vid_addr = 10'h020;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'hFF;
    @(negedge clk);
    check("drop_cgnt", 32'(cpu_gnt), 32'd0);
    check("drop_vgnt", 32'(vid_gnt), 32'd1);
    next_cycle();
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("drop_vdata", 32'(vid_data), 32'h7E);
    next_cycle();
    cpu_read("drop_kept", 11'h010, 8'h3C);

    // Starvation: video holds the tile bank, CPU forced in on cycle 9.
    blank = 1'b0;
    vid_req = 1'b1; vid_sel = 1'b0; vid_addr = 10'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h040;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c < 9) begin
        check($sformatf("starve%0d_cgnt", c), 32'(cpu_gnt), 32'd0);
        check($sformatf("starve%0d_vgnt", c), 32'(vid_gnt), 32'd1);
      end else begin
        check("starve9_cgnt", 32'(cpu_gnt), 32'd1);
        check("starve9_vgnt", 32'(vid_gnt), 32'd0);
      end
      next_cycle();
    end
    cpu_req = 1'b0;
    @(negedge clk);
    check("starve10_vgnt",   32'(vid_gnt),    32'd1);
    check("starve10_vvalid", 32'(vid_valid),  32'd0);
    check("starve10_rvalid", 32'(cpu_rvalid), 32'd1);
    check("starve10_rdata",  32'(cpu_rdata),  32'h99);
    next_cycle();
    vid_req = 1'b0;
    @(negedge clk);
    check("starve11_vvalid", 32'(vid_valid), 32'd1);
    check("starve11_vdata",  32'(vid_data),  32'h3C);
    next_cycle();

    // Different banks in the same cycle: both granted.
    blank = 1'b0;
    vid_req = 1'b1; vid_sel = 1'b0; vid_addr = 10'h001;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h401;
    @(negedge clk);
    check("par_vgnt", 32'(vid_gnt), 32'd1);
    check("par_cgnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    vid_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("par_vvalid", 32'(vid_valid),  32'd1);
    check("par_vdata",  32'(vid_data),   32'h5A);
    check("par_rvalid", 32'(cpu_rvalid), 32'd1);
    check("par_rdata",  32'(cpu_rdata),  32'hC3);
    next_cycle();

    // Blanking conflict: CPU wins.
    blank = 1'b1;
    vid_req = 1'b1; vid_sel = 1'b0; vid_addr = 10'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
    @(negedge clk);
    check("blank_cgnt", 32'(cpu_gnt), 32'd1);
    check("blank_vgnt", 32'(vid_gnt), 32'd0);
    next_cycle();
    vid_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("blank_rdata",  32'(cpu_rdata), 32'h7E);
    check("blank_vvalid", 32'(vid_valid), 32'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
